// File: rtl/tinker_io_pkg.sv
// Shared types and constants for the Tinker CPU host-side I/O blocks.
//   DefaultWordW : default data width of the CPU output port
//   sink_state_t : output-sink lifecycle (RUN -> DRAIN -> DONE)
package tinker_io_pkg;

  localparam int unsigned DefaultWordW = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sink_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, reset    : rising-edge clock, synchronous active-low reset
//   push_i        : write request; ignored when full unless a pop occurs the same cycle
//   push_data_i   : word written on an accepted push
//   pop_i         : read request; ignored when empty
//   head_data_o   : word at the head (meaningful only when count_o != 0)
//   count_o       : number of stored words; DEPTH means full
module io_sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WORD_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WORD_W-1:0]            push_data_i,
  input  logic                         pop_i,
  output logic [WORD_W-1:0]            head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != Full) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage carries no reset; count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/tinker_out_sink.sv
// Host-side responder for the Tinker CPU output port. Captures every word strobed on
// out_signal/out_data into a FIFO, streams it to the host over ready/valid, and after
// halt drains the FIFO and raises done.
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   out_signal/out_data : CPU output strobe and word
//   halt                : CPU halt level
//   host_valid/_data    : head word (first-word-fall-through)
//   host_ready          : host accepts head word when host_valid is high
//   count               : words currently stored
//   overflow            : sticky, a word was dropped on a full FIFO
//   done                : sticky, halt seen and FIFO drained
module tinker_out_sink #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WORD_W = tinker_io_pkg::DefaultWordW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       out_signal,
  input  logic [WORD_W-1:0]          out_data,
  input  logic                       halt,
  output logic                       host_valid,
  output logic [WORD_W-1:0]          host_data,
  input  logic                       host_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       done
);

  import tinker_io_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  sink_state_t     state_q;
  logic            overflow_q, done_q;
  logic            push, pop;
  logic [CntW-1:0] fifo_count;

  // Outputs depend only on registered state; host_ready and out_signal feed edges only.
  assign host_valid = (fifo_count != '0);
  assign pop        = host_valid && host_ready;
  assign push       = (state_q == RUN) && out_signal;

  io_sync_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (out_data),
    .pop_i       (pop),
    .head_data_o (host_data),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (push && (fifo_count == Full) && !pop) overflow_q <= 1'b1;
      case (state_q)
        RUN: begin
          // A push in the halt cycle is still taken (push is gated on RUN, not halt).
          if (halt) state_q <= DRAIN;
        end
        DRAIN: begin
          if (fifo_count == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign count    = fifo_count;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tinker_out_sink.sv
module tb_tinker_out_sink;

  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_signal;
  logic [63:0] out_data;
  logic        halt;
  logic        host_valid;
  logic [63:0] host_data;
  logic        host_ready;
  logic [4:0]  count;
  logic        overflow;
  logic        done;

  int total = 0;
  int bad   = 0;

  // Reference model: word queue plus lifecycle flags.
  logic [63:0] mq[$];
  bit          m_ovf, m_halted, m_done;
  int          rx_cnt;
  logic [63:0] rx_words[$];

  always #5 clk = ~clk;

  tinker_out_sink #(
    .DEPTH  (Depth),
    .WORD_W (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .out_signal (out_signal),
    .out_data   (out_data),
    .halt       (halt),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .count      (count),
    .overflow   (overflow),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then check outputs.
  task automatic step(input logic r, input logic sig, input logic [63:0] d,
                      input logic h, input logic rdy);
    int sz;
    bit do_pop;
    bit nxt_h, nxt_d;
    reset = r; out_signal = sig; out_data = d; halt = h; host_ready = rdy;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_ovf = 0; m_halted = 0; m_done = 0;
    end else begin
      sz     = mq.size();
      do_pop = (sz > 0) && rdy;
      nxt_h  = m_halted;
      nxt_d  = m_done;
      if (!m_halted && h) nxt_h = 1;
      if (m_halted && !m_done && sz == 0) nxt_d = 1;
      if (do_pop) begin
        rx_words.push_back(mq.pop_front());
        rx_cnt++;
      end
      if (!m_halted && sig) begin
        if (sz < Depth || do_pop) mq.push_back(d);
        else m_ovf = 1;
      end
      m_halted = nxt_h;
      m_done   = nxt_d;
    end
    #1;
    chk("count", 64'(count), 64'(mq.size()));
    chk("host_valid", 64'(host_valid), 64'(mq.size() > 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("done", 64'(done), 64'(m_done));
    if (mq.size() > 0) chk("host_data", host_data, mq[0]);
  endtask

  initial begin
    int n;
    int cyc;
    logic [63:0] w;
    m_ovf = 0; m_halted = 0; m_done = 0; rx_cnt = 0;
    reset = 1'b0; out_signal = 1'b0; out_data = '0; halt = 1'b0; host_ready = 1'b0;

    // Reset hold with strobe active.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b0);

    // Ordered stream 5, 6, 7 with host always ready.
    rx_words.delete();
    step(1'b1, 1'b1, 64'd5, 1'b0, 1'b1);
    step(1'b1, 1'b1, 64'd6, 1'b0, 1'b1);
    step(1'b1, 1'b1, 64'd7, 1'b0, 1'b1);
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("stream_n", 64'(rx_words.size()), 64'd3);
    if (rx_words.size() == 3) begin
      chk("stream_w0", rx_words[0], 64'd5);
      chk("stream_w2", rx_words[2], 64'd7);
    end

    // Overflow: 18 words into a 16-deep FIFO, then drain.
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 64'(i), 1'b0, 1'b0);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    rx_words.delete();
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("ovf_drain_n", 64'(rx_words.size()), 64'd16);
    if (rx_words.size() == 16) chk("ovf_last", rx_words[15], 64'hF);

    // Full with simultaneous push and pop.
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'hAA, 1'b0, 1'b1);
    chk("full_pp_count", 64'(count), 64'd16);
    chk("full_pp_ovf", 64'(overflow), 64'd0);
    rx_words.delete();
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    if (rx_words.size() > 0) chk("full_pp_last", rx_words[rx_words.size()-1], 64'hAA);

    // Halt drain with ignored strobe.
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 64'h30 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'hBAD, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'hBAD, 1'b0, 1'b0);
    chk("halt_count", 64'(count), 64'd3);
    rx_words.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 64'hBAD, 1'b0, 1'b1);
    chk("halt_rx_n", 64'(rx_words.size()), 64'd3);
    chk("halt_done", 64'(done), 64'd1);

    // Wrap: 40 words, host ready every other cycle.
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    rx_cnt = 0; n = 0; cyc = 0;
    rx_words.delete();
    while (rx_cnt < 40 && cyc < 400) begin
      if (n < 40 && mq.size() < 15) begin
        step(1'b1, 1'b1, 64'h1000 + 64'(n), 1'b0, 1'(cyc % 2));
        n++;
      end else begin
        step(1'b1, 1'b0, 64'd0, 1'b0, 1'(cyc % 2));
      end
      cyc++;
    end
    chk("wrap_rx", 64'(rx_cnt), 64'd40);
    for (int i = 0; i < rx_words.size(); i++) begin
      w = 64'h1000 + 64'(i);
      if (rx_words[i] !== w) chk("wrap_order", rx_words[i], w);
    end

    // Reset mid-run with 4 words queued.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 64'h50 + 64'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd4);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("post_rst_count", 64'(count), 64'd0);

    // Randomized traffic against the model; halt is rare.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), {$urandom, $urandom},
           ($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinker_out_sink.md
# tinker_out_sink

Host-side responder for the Tinker CPU output port. It captures every word the CPU presents on `out_signal`/`out_data` into a FIFO and hands the words to the bench or host over a ready/valid stream. When the CPU asserts `halt`, it drains the remaining words and then raises `done`, so a test can wait for the end of a program's output. It sits outside `cpu`, wired directly to the `cpu` instance's output and halt ports.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `WORD_W`, 64: data width; matches `out_data`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-low; state clears on a rising `clk` edge while `reset`=0.
- `out_signal`, input, 1: CPU output strobe. One word per cycle it is high.
- `out_data`, input, WORD_W: CPU output word, valid when `out_signal`=1.
- `halt`, input, 1: CPU halt indication (level).
- `host_valid`, output, 1: head word is available.
- `host_data`, output, WORD_W: head word (first-word-fall-through); undefined when `host_valid`=0.
- `host_ready`, input, 1: host accepts the head word on an edge where `host_valid`=1.
- `count`, output, $clog2(DEPTH+1): number of words in the FIFO.
- `overflow`, output, 1: sticky; set when a word was dropped because the FIFO was full.
- `done`, output, 1: sticky; halt seen and FIFO fully drained.

## Operation
- Push: `out_signal`=1 in state RUN pushes `out_data`, unless the FIFO is full with no pop that cycle.
- Pop: happens when `host_valid` and `host_ready` are both 1.
- Full with push and pop in the same cycle: both occur; `count` is unchanged.
- Full with push and no pop: the word is dropped, `count` stays at DEPTH, and `overflow` is set on the next edge.
- Empty with push and no pop: the word is pushed normally.
- Empty with push and pop in the same cycle: no pop occurs, because `host_valid`=0.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` carries the full/empty information (full when `count`=DEPTH).
- State machine, one-hot or binary:
  - RUN → DRAIN on an edge where `halt`=1. A push in that same cycle is still accepted.
  - DRAIN: `out_signal` is ignored (no push, no overflow). Goes to DONE on the first edge where `count`=0.
  - DONE: terminal; `done`=1. Only reset leaves it. `out_signal` is still ignored, and `halt` has no further effect.
- `halt` dropping after entry to DRAIN has no effect.

## Timing
- Reset values: `host_valid`=0, `count`=0, `overflow`=0, `done`=0, state RUN, pointers 0. `host_data` is don't-care.
- Reset mid-operation discards all stored words on that edge.
- Latency:
  - Push on edge N gives `host_valid`=1 and the word on `host_data` after edge N (zero wait for the host).
  - Pop on edge N shows the next word, or `host_valid`=0, after edge N.
- `host_valid`, `host_data`, `count`, `overflow` and `done` are all registered or derived from registered state only. There is no combinational path from `host_ready` or `out_signal` to any output.
- Halt with an empty FIFO:
  - halt sampled at edge N puts the block in DRAIN after N.
  - `count`=0 sampled at edge N+1 gives `done`=1 after N+1.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- Package `tinker_io_pkg`: `WORD_W` default constant, and the state enum `sink_state_t` {RUN, DRAIN, DONE}.
- Sub-module `io_sync_fifo`:
  - Ports: `clk`, `reset`, push/data, pop, head data, count.
  - Same reset convention as this block.
  - Reusable later for an input-side feeder.
- The top level holds the state machine, push gating, and the sticky `overflow` and `done` flags.

## Test plan
- Reset hold: `reset`=0 for 3 cycles while `out_signal`=1 → `count`=0, `host_valid`=0, `overflow`=0, `done`=0 throughout.
- Ordered stream: push 5, 6, 7 in consecutive cycles with `host_ready`=1 → `host_data` shows 5, 6, 7 on consecutive cycles starting 1 cycle after the first push; `count` never exceeds 1.
- Overflow (DEPTH=16): push 0x0..0x11 (18 words) with `host_ready`=0 → `count`=16 and `overflow`=1. Then draining yields 0x0..0xF, and `overflow` stays 1.
- Full with simultaneous push/pop: with a full FIFO, push 0xAA in the same cycle as a pop → `count` stays 16, `overflow`=0, and 0xAA is the last word out.
- Halt drain: 3 words queued, `halt`=1 with `host_ready`=0, `out_signal` pulsed with 0xBAD during DRAIN → 0xBAD never appears. With `host_ready`=1, 3 words come out, and `done`=1 on the edge after `count` reaches 0.
- Wrap plus reset mid-run: stream 40 words through DEPTH=16 with the host ready only every other cycle → all 40 arrive in order. Then, with 4 words queued, pull `reset` low for 1 cycle → `count`=0 and `host_valid`=0 on the following cycle.
